// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing and the per-entry record.
// DEPTH must be a power of two and TAG_W must equal log2(DEPTH).
package rob_pkg;

   localparam int DEPTH = 8;
   localparam int TAG_W = 3;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic [4:0]  dest;
      logic [31:0] data;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at the tail, captures CDB results,
// retires from the head one entry per cycle, and forwards operands to the regfile.
module reorder_buffer
   import rob_pkg::rob_entry_t;
#(
   parameter int DEPTH = rob_pkg::DEPTH,
   parameter int TAG_W = rob_pkg::TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_dest,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_data,
   output logic             commit_load,
   output logic [4:0]       commit_dest,
   output logic [31:0]      commit_data,
   output logic [TAG_W-1:0] commit_tag,
   input  logic [TAG_W-1:0] rd_tag_a,
   input  logic [TAG_W-1:0] rd_tag_b,
   output logic             rd_ready_a,
   output logic             rd_ready_b,
   output logic [31:0]      rd_data_a,
   output logic [31:0]      rd_data_b,
   input  logic             flush,
   output logic [TAG_W:0]   count
);

   localparam int PTR_W = TAG_W + 1;

   rob_entry_t       entries [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head_nxt;
   logic [PTR_W-1:0] tail_nxt;
   logic [TAG_W-1:0] head_idx;
   logic [TAG_W-1:0] tail_idx;
   logic             full;
   logic             alloc_fire;
   logic             cdb_hit;

   assign head_idx = head[TAG_W-1:0];
   assign tail_idx = tail[TAG_W-1:0];

   // Extra wrap bit distinguishes full from empty when the indices coincide.
   assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
   assign alloc_ready = !full;
   assign alloc_tag   = tail_idx;

   assign alloc_fire = alloc_valid && !full && !flush;
   assign cdb_hit    = cdb_valid && entries[cdb_tag].busy && !entries[cdb_tag].done && !flush;

   assign head_nxt = head + PTR_W'(commit_load);
   assign tail_nxt = tail + PTR_W'(alloc_fire);

   always_comb begin
      commit_load = 1'b0;
      commit_dest = '0;
      commit_data = '0;
      commit_tag  = '0;
      if (entries[head_idx].busy && entries[head_idx].done && !flush) begin
         commit_load = 1'b1;
         commit_dest = entries[head_idx].dest;
         commit_data = entries[head_idx].data;
         commit_tag  = head_idx;
      end
   end

   // Stored results win over a same-cycle broadcast; the broadcast covers the
   // cycle before the result lands in the entry.
   always_comb begin
      rd_ready_a = 1'b0;
      rd_data_a  = '0;
      if (entries[rd_tag_a].busy && entries[rd_tag_a].done) begin
         rd_ready_a = 1'b1;
         rd_data_a  = entries[rd_tag_a].data;
      end else if (cdb_valid && (cdb_tag == rd_tag_a)) begin
         rd_ready_a = 1'b1;
         rd_data_a  = cdb_data;
      end
   end

   always_comb begin
      rd_ready_b = 1'b0;
      rd_data_b  = '0;
      if (entries[rd_tag_b].busy && entries[rd_tag_b].done) begin
         rd_ready_b = 1'b1;
         rd_data_b  = entries[rd_tag_b].data;
      end else if (cdb_valid && (cdb_tag == rd_tag_b)) begin
         rd_ready_b = 1'b1;
         rd_data_b  = cdb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i].busy <= 1'b0;
            entries[i].done <= 1'b0;
         end
      end else begin
         if (alloc_fire) begin
            entries[tail_idx].busy <= 1'b1;
            entries[tail_idx].done <= 1'b0;
            entries[tail_idx].dest <= alloc_dest;
         end
         if (cdb_hit) begin
            entries[cdb_tag].done <= 1'b1;
            entries[cdb_tag].data <= cdb_data;
         end
         if (commit_load) begin
            entries[head_idx].busy <= 1'b0;
         end
         head  <= head_nxt;
         tail  <= tail_nxt;
         count <= tail_nxt - head_nxt;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a hand-computed vector table plus a queue-based
// reference model of in-flight entries checked every cycle.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alloc_valid;
   logic [4:0]  alloc_dest;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        commit_load;
   logic [4:0]  commit_dest;
   logic [31:0] commit_data;
   logic [2:0]  commit_tag;
   logic [2:0]  rd_tag_a;
   logic [2:0]  rd_tag_b;
   logic        rd_ready_a;
   logic        rd_ready_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        flush;
   logic [3:0]  count;

   reorder_buffer dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .commit_load(commit_load), .commit_dest(commit_dest),
      .commit_data(commit_data), .commit_tag(commit_tag),
      .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
      .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .flush(flush), .count(count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;

   typedef struct {
      logic [2:0] tag;
      logic [4:0] dest;
   } sb_t;

   sb_t         sb_q[$];
   logic        sb_done [8];
   logic [31:0] sb_data [8];
   int          sb_tail;

   logic        o_ready;
   logic [2:0]  o_tag;
   logic        o_cl;
   logic [4:0]  o_cdest;
   logic [31:0] o_cdata;
   logic [3:0]  o_count;

   typedef struct {
      logic        av;
      logic [4:0]  ad;
      logic        cv;
      logic [2:0]  ct;
      logic [31:0] cd;
      logic        fl;
      logic        e_ready;
      logic [2:0]  e_tag;
      logic        e_cl;
      logic [4:0]  e_cdest;
      logic [31:0] e_cdata;
      logic [3:0]  e_count;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      sb_tail = 0;
      for (int i = 0; i < 8; i++) begin
         sb_done[i] = 1'b0;
         sb_data[i] = 32'd0;
      end
   endtask

   function automatic logic in_q(input logic [2:0] t);
      foreach (sb_q[i]) begin
         if (sb_q[i].tag == t) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [32:0] exp_rd(input logic [2:0] t, input logic cv,
                                          input logic [2:0] ct, input logic [31:0] cd);
      if (in_q(t) && sb_done[t]) return {1'b1, sb_data[t]};
      if (cv && (ct == t)) return {1'b1, cd};
      return 33'd0;
   endfunction

   // One clock cycle: drive at negedge, check against the model, then update it.
   task automatic step(input logic av, input logic [4:0] ad, input logic cv,
                       input logic [2:0] ct, input logic [31:0] cd, input logic fl,
                       input logic [2:0] ra, input logic [2:0] rb);
      logic        e_ready;
      logic        e_cl;
      logic [32:0] e_rd;
      @(negedge clk);
      alloc_valid = av;
      alloc_dest  = ad;
      cdb_valid   = cv;
      cdb_tag     = ct;
      cdb_data    = cd;
      flush       = fl;
      rd_tag_a    = ra;
      rd_tag_b    = rb;
      #1;
      o_ready = alloc_ready;
      o_tag   = alloc_tag;
      o_cl    = commit_load;
      o_cdest = commit_dest;
      o_cdata = commit_data;
      o_count = count;
      e_ready = (sb_q.size() < 8);
      e_cl    = (sb_q.size() > 0) && sb_done[sb_q[0].tag] && !fl;
      chk("alloc_ready", 32'(alloc_ready), 32'(e_ready));
      chk("alloc_tag", 32'(alloc_tag), 32'(sb_tail));
      chk("count", 32'(count), 32'(sb_q.size()));
      chk("commit_load", 32'(commit_load), 32'(e_cl));
      if (e_cl) begin
         chk("commit_dest", 32'(commit_dest), 32'(sb_q[0].dest));
         chk("commit_data", commit_data, sb_data[sb_q[0].tag]);
         chk("commit_tag", 32'(commit_tag), 32'(sb_q[0].tag));
      end else begin
         chk("commit_data_idle", commit_data, 32'd0);
         chk("commit_dest_tag_idle", 32'({commit_tag, commit_dest}), 32'd0);
      end
      e_rd = exp_rd(ra, cv, ct, cd);
      chk("rd_ready_a", 32'(rd_ready_a), 32'(e_rd[32]));
      chk("rd_data_a", rd_data_a, e_rd[31:0]);
      e_rd = exp_rd(rb, cv, ct, cd);
      chk("rd_ready_b", 32'(rd_ready_b), 32'(e_rd[32]));
      chk("rd_data_b", rd_data_b, e_rd[31:0]);
      if (fl) begin
         model_reset();
      end else begin
         if (e_cl) begin
            sb_done[sb_q[0].tag] = 1'b0;
            void'(sb_q.pop_front());
         end
         if (cv && in_q(ct) && !sb_done[ct]) begin
            sb_done[ct] = 1'b1;
            sb_data[ct] = cd;
         end
         if (av && e_ready) begin
            sb_q.push_back('{tag: 3'(sb_tail), dest: ad});
            sb_tail = (sb_tail + 1) % 8;
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
   endtask

   task automatic do_alloc(input logic [4:0] d);
      step(1'b1, d, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
   endtask

   task automatic do_cdb(input logic [2:0] t, input logic [31:0] d);
      step(1'b0, 5'd0, 1'b1, t, d, 1'b0, 3'd0, 3'd0);
   endtask

   task automatic do_flush();
      step(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd0, 3'd0);
   endtask

   initial begin
      //                av    ad     cv    ct    cd             fl     rdy   tag   cl    cdest  cdata          count
      vecs[0]  = '{1'b1, 5'd5, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,        4'd0};
      vecs[1]  = '{1'b0, 5'd0, 1'b1, 3'd0, 32'hDEADBEEF, 1'b0, 1'b1, 3'd1, 1'b0, 5'd0, 32'h0,        4'd1};
      vecs[2]  = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 32'hDEADBEEF, 4'd1};
      vecs[3]  = '{1'b1, 5'd7, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd1, 1'b0, 5'd0, 32'h0,        4'd0};
      vecs[4]  = '{1'b1, 5'd8, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd2, 1'b0, 5'd0, 32'h0,        4'd1};
      vecs[5]  = '{1'b1, 5'd0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd3, 1'b0, 5'd0, 32'h0,        4'd2};
      vecs[6]  = '{1'b0, 5'd0, 1'b1, 3'd3, 32'h33,       1'b0, 1'b1, 3'd4, 1'b0, 5'd0, 32'h0,        4'd3};
      vecs[7]  = '{1'b0, 5'd0, 1'b1, 3'd2, 32'h22,       1'b0, 1'b1, 3'd4, 1'b0, 5'd0, 32'h0,        4'd3};
      vecs[8]  = '{1'b0, 5'd0, 1'b1, 3'd1, 32'h11,       1'b0, 1'b1, 3'd4, 1'b0, 5'd0, 32'h0,        4'd3};
      vecs[9]  = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd4, 1'b1, 5'd7, 32'h11,       4'd3};
      vecs[10] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd4, 1'b1, 5'd8, 32'h22,       4'd2};
      vecs[11] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd4, 1'b1, 5'd0, 32'h33,       4'd1};
      vecs[12] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 3'd4, 1'b0, 5'd0, 32'h0,        4'd0};
      vecs[13] = '{1'b1, 5'd9, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,        4'd0};
      vecs[14] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 3'd1, 1'b0, 5'd0, 32'h0,        4'd1};

      alloc_valid = 1'b0;
      alloc_dest  = 5'd0;
      cdb_valid   = 1'b0;
      cdb_tag     = 3'd0;
      cdb_data    = 32'd0;
      flush       = 1'b0;
      rd_tag_a    = 3'd0;
      rd_tag_b    = 3'd0;
      model_reset();

      #12;
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
      chk("rst_commit_load", 32'(commit_load), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rd_ready_a", 32'(rd_ready_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         step(vecs[i].av, vecs[i].ad, vecs[i].cv, vecs[i].ct, vecs[i].cd, vecs[i].fl, 3'd0, 3'd0);
         chk($sformatf("vec%0d_ready", i), 32'(o_ready), 32'(vecs[i].e_ready));
         chk($sformatf("vec%0d_tag", i), 32'(o_tag), 32'(vecs[i].e_tag));
         chk($sformatf("vec%0d_cl", i), 32'(o_cl), 32'(vecs[i].e_cl));
         chk($sformatf("vec%0d_cdest", i), 32'(o_cdest), 32'(vecs[i].e_cdest));
         chk($sformatf("vec%0d_cdata", i), o_cdata, vecs[i].e_cdata);
         chk($sformatf("vec%0d_count", i), 32'(o_count), 32'(vecs[i].e_count));
      end

      // Fill to full, refuse a 9th, then commit-while-full and wrap the tail.
      do_flush();
      for (int i = 0; i < 8; i++) do_alloc(5'(10 + i));
      do_alloc(5'd30);
      chk("full_count", 32'(o_count), 32'd8);
      chk("full_ready", 32'(o_ready), 32'd0);
      chk("full_tag_hold", 32'(o_tag), 32'd0);
      step(1'b1, 5'd30, 1'b1, 3'd0, 32'hA0, 1'b0, 3'd0, 3'd0);
      step(1'b1, 5'd20, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
      chk("full_commit", 32'(o_cl), 32'd1);
      chk("full_commit_refuse", 32'(o_ready), 32'd0);
      do_alloc(5'd20);
      chk("wrap_ready", 32'(o_ready), 32'd1);
      chk("wrap_tag", 32'(o_tag), 32'd0);

      // Operand forwarding: broadcast path, then stored path.
      step(1'b0, 5'd0, 1'b1, 3'd3, 32'h1234, 1'b0, 3'd3, 3'd4);
      chk("fwd_cdb_ready", 32'(rd_ready_a), 32'd1);
      chk("fwd_cdb_data", rd_data_a, 32'h1234);
      step(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd3, 3'd4);
      chk("fwd_store_data", rd_data_a, 32'h1234);
      chk("fwd_notdone_b", 32'(rd_ready_b), 32'd0);

      // Flush with five entries, head and one other done.
      do_flush();
      for (int i = 0; i < 5; i++) do_alloc(5'(1 + i));
      do_cdb(3'd3, 32'h77);
      do_cdb(3'd0, 32'h66);
      do_flush();
      chk("flush_no_commit", 32'(o_cl), 32'd0);
      idle();
      chk("flush_count", 32'(o_count), 32'd0);
      chk("flush_tag", 32'(o_tag), 32'd0);

      // Asynchronous reset in the low phase with a retirement pending.
      do_alloc(5'd6);
      do_cdb(3'd0, 32'h55);
      @(negedge clk);
      alloc_valid = 1'b0;
      cdb_valid   = 1'b0;
      flush       = 1'b0;
      #1;
      chk("pre_rst_commit", 32'(commit_load), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_commit", 32'(commit_load), 32'd0);
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_tag", 32'(alloc_tag), 32'd0);
      chk("async_rst_ready", 32'(alloc_ready), 32'd1);
      chk("async_rst_cdata", commit_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      idle();
      do_alloc(5'd4);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, 8, number of entries; SHALL be a power of two.
REQ-002 Parameter TAG_W, 3, tag width; SHALL equal log2(DEPTH).
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 alloc_valid  in  1  instruction queue requests an entry.
REQ-006 alloc_dest  in  5  architectural destination register of the requesting instruction.
REQ-007 alloc_ready  out  1  entry available (not full).
REQ-008 alloc_tag  out  TAG_W  tag granted on this cycle's allocation (tail index); also drives regfile tag_in.
REQ-009 cdb_valid  in  1  CDB broadcast present.
REQ-010 cdb_tag  in  TAG_W  tag of broadcast result.
REQ-011 cdb_data  in  32  broadcast result value.
REQ-012 commit_load  out  1  head entry retiring this cycle; drives regfile load.
REQ-013 commit_dest  out  5  destination of retiring entry.
REQ-014 commit_data  out  32  value of retiring entry.
REQ-015 commit_tag  out  TAG_W  tag of retiring entry, for regfile tag match.
REQ-016 rd_tag_a, rd_tag_b  in  TAG_W  operand tags reported by the regfile.
REQ-017 rd_ready_a, rd_ready_b  out  1  operand value available from ROB.
REQ-018 rd_data_a, rd_data_b  out  32  operand value from ROB.
REQ-019 flush  in  1  discard all entries.
REQ-020 count  out  TAG_W+1  occupied entries, 0..DEPTH.

Function
REQ-021 Storage SHALL be a circular buffer; head/tail pointers TAG_W+1 bits wide; full = index bits equal and wrap bits differ; empty = pointers equal.
REQ-022 alloc_ready SHALL be !full, computed from current state only (no bypass from same-cycle commit).
REQ-023 alloc_tag SHALL equal tail index combinationally, valid whenever alloc_ready.
REQ-024 On alloc_valid && alloc_ready: entry[tail] busy=1, done=0, dest=alloc_dest; tail increments with wrap at next edge.
REQ-025 alloc_valid while full SHALL be ignored with no state change.
REQ-026 On cdb_valid with entry[cdb_tag] busy and not done: done=1, data=cdb_data at next edge; otherwise broadcast ignored.
REQ-027 commit_load SHALL be 1 combinationally when entry[head] busy && done && !flush; commit_dest/data/tag reflect entry[head]; all three SHALL be 0 when commit_load is 0.
REQ-028 On commit: entry[head] busy=0, head increments with wrap; at most one commit per cycle, strictly in order.
REQ-029 CDB to head entry SHALL cause commit_load exactly one cycle later (registered done, no same-cycle commit).
REQ-030 Allocation and commit in the same cycle SHALL both occur; count unchanged.
REQ-031 alloc_dest = 0 SHALL allocate normally and commit with commit_dest = 0.
REQ-032 rd_ready_x = 1 when entry[rd_tag_x] busy && done (rd_data_x = stored data), else when cdb_valid && cdb_tag == rd_tag_x (rd_data_x = cdb_data); otherwise rd_ready_x = 0, rd_data_x = 0.
REQ-033 flush SHALL be synchronous, take priority over alloc, CDB and commit: all busy/done cleared, head = tail = 0, count = 0.
REQ-034 count SHALL equal tail - head modulo 2*DEPTH, registered.

Reset
REQ-035 Asserting rst SHALL immediately clear head, tail, count, every busy/done bit and stored data/dest to 0, independent of clk.
REQ-036 During and after reset: alloc_ready = 1, alloc_tag = 0, commit_load = 0, commit outputs 0, rd_ready_x = 0 unless forwarded from CDB.
REQ-037 Reset mid-operation SHALL discard all in-flight entries with no commit issued.

Structure
REQ-038 DEPTH, TAG_W and the entry struct rob_entry_t (busy, done, dest[4:0], data[31:0]) SHALL live in shared package rob_pkg.
REQ-039 Single module, no sub-module; entry array and pointer logic inline.

Verification
REQ-040 Reset, alloc dest x5 -> alloc_tag 0; CDB tag 0 data 0xDEADBEEF -> next cycle commit_load=1, commit_dest=5, commit_data=0xDEADBEEF, commit_tag=0.
REQ-041 Allocate 8 without CDB -> count=8, alloc_ready=0; 9th alloc_valid ignored, tail unchanged.
REQ-042 Tags 0,1,2 allocated; CDB order 2,1,0 -> commits strictly 0,1,2 on three consecutive cycles.
REQ-043 Full buffer, head done, alloc_valid high -> commit occurs, alloc refused that cycle, accepted next; tag wraps to 0 after 7.
REQ-044 rd_tag_a=3 with CDB tag 3 data 0x1234 same cycle -> rd_ready_a=1, rd_data_a=0x1234; next cycle same from storage.
REQ-045 Flush with 5 entries, 2 done -> no commit_load, count=0, alloc_tag=0 next cycle; async rst mid-clock -> outputs cleared immediately.
